// File: rtl/coin_collector.sv
// Per-frame player/coin overlap detector with collected mask and saturating 4-digit BCD score.
// Optional COIN_COMBO_EN: 2nd/3rd collect in one frame add 2x/3x POINTS.
module coin_collector #(
  parameter int PLAYER_W  = 120,
  parameter int PLAYER_H  = 40,
  parameter int COIN_SIZE = 50,
  parameter int POINTS    = 1
) (
  input  logic        CLK,
  input  logic        RST_BTN,
  input  logic        frame_stb,
  input  logic [9:0]  player_x,
  input  logic [8:0]  player_y,
  input  logic [29:0] coins_x,
  input  logic [26:0] coins_y,
  input  logic [5:0]  coins,
  output logic [2:0]  collected,
  output logic [15:0] score_bcd,
  output logic        collect_pulse,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CHK, INC, DONE} state_t;

  localparam logic [10:0] PW_X = 11'(PLAYER_W);
  localparam logic [10:0] CS_X = 11'(COIN_SIZE);
  localparam logic [9:0]  PH_Y = 10'(PLAYER_H);
  localparam logic [9:0]  CS_Y = 10'(COIN_SIZE);

  function automatic logic [7:0] to_bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  localparam logic [7:0] ADD1 = to_bcd8(POINTS);
`ifdef COIN_COMBO_EN
  localparam logic [7:0] ADD2 = to_bcd8(2 * POINTS);
  localparam logic [7:0] ADD3 = to_bcd8(3 * POINTS);
`endif

  // Digit-serial decimal add; a carry out of the thousands digit pins the score at 9999.
  function automatic logic [15:0] bcd_add(input logic [15:0] s, input logic [7:0] a);
    logic [15:0] r;
    logic [15:0] ae;
    logic [4:0]  d;
    logic        c;
    ae = {8'h00, a};
    r  = '0;
    c  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, s[4*i +: 4]} + {1'b0, ae[4*i +: 4]} + {4'b0000, c};
      if (d > 5'd9) begin
        d = d - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = d[3:0];
    end
    return c ? 16'h9999 : r;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  hit_q, hit_d;
  logic [1:0]  inc_cnt_q, inc_cnt_d;
  logic [9:0]  snap_px_q, snap_px_d;
  logic [8:0]  snap_py_q, snap_py_d;
  logic [29:0] snap_cx_q, snap_cx_d;
  logic [26:0] snap_cy_q, snap_cy_d;
  logic [5:0]  snap_coins_q, snap_coins_d;
  logic [2:0]  collected_q, collected_d;
  logic [15:0] score_q, score_d;
  logic [5:0]  coins_prev_q, coins_prev_d;

  logic [9:0]  sel_cx;
  logic [8:0]  sel_cy;
  logic [1:0]  sel_st;
  logic        sel_coll;
  logic        hit_now;
  logic [2:0]  inc_oh;
  logic [2:0]  respawn;
  logic [7:0]  add_val;

  always_comb begin
    sel_cx   = snap_cx_q[9:0];
    sel_cy   = snap_cy_q[8:0];
    sel_st   = snap_coins_q[1:0];
    sel_coll = collected_q[0];
    case (idx_q)
      2'd1: begin
        sel_cx   = snap_cx_q[19:10];
        sel_cy   = snap_cy_q[17:9];
        sel_st   = snap_coins_q[3:2];
        sel_coll = collected_q[1];
      end
      2'd2: begin
        sel_cx   = snap_cx_q[29:20];
        sel_cy   = snap_cy_q[26:18];
        sel_st   = snap_coins_q[5:4];
        sel_coll = collected_q[2];
      end
      default: ;
    endcase
  end

  // Sums are widened one bit so a box near the screen edge cannot wrap.
  assign hit_now = (sel_st != 2'b00) && !sel_coll
                && ({1'b0, snap_px_q} < {1'b0, sel_cx} + CS_X)
                && ({1'b0, sel_cx} < {1'b0, snap_px_q} + PW_X)
                && ({1'b0, snap_py_q} < {1'b0, sel_cy} + CS_Y)
                && ({1'b0, sel_cy} < {1'b0, snap_py_q} + PH_Y);

  assign inc_oh = hit_q & (~hit_q + 3'd1);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      respawn[i] = (coins[2*i +: 2] != coins_prev_q[2*i +: 2]);
    end
  end

`ifdef COIN_COMBO_EN
  always_comb begin
    case (inc_cnt_q)
      2'd0:    add_val = ADD1;
      2'd1:    add_val = ADD2;
      default: add_val = ADD3;
    endcase
  end
`else
  assign add_val = ADD1;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hit_d        = hit_q;
    inc_cnt_d    = inc_cnt_q;
    snap_px_d    = snap_px_q;
    snap_py_d    = snap_py_q;
    snap_cx_d    = snap_cx_q;
    snap_cy_d    = snap_cy_q;
    snap_coins_d = snap_coins_q;
    collected_d  = collected_q;
    score_d      = score_q;
    coins_prev_d = coins;

    case (state_q)
      IDLE: begin
        if (frame_stb) begin
          snap_px_d    = player_x;
          snap_py_d    = player_y;
          snap_cx_d    = coins_x;
          snap_cy_d    = coins_y;
          snap_coins_d = coins;
          hit_d        = 3'b000;
          idx_d        = 2'd0;
          inc_cnt_d    = 2'd0;
          state_d      = CHK;
        end
      end
      CHK: begin
        hit_d = hit_q | ({2'b00, hit_now} << idx_q);
        if (idx_q == 2'd2) begin
          state_d = (hit_d != 3'b000) ? INC : DONE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      INC: begin
        score_d     = bcd_add(score_q, add_val);
        collected_d = collected_q | inc_oh;
        hit_d       = hit_q & ~inc_oh;
        inc_cnt_d   = inc_cnt_q + 2'd1;
        if (hit_d == 3'b000) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A changed live slot means a respawn; it overrides any set from the stale snapshot.
    collected_d = collected_d & ~respawn;
  end

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      hit_q        <= '0;
      inc_cnt_q    <= '0;
      snap_px_q    <= '0;
      snap_py_q    <= '0;
      snap_cx_q    <= '0;
      snap_cy_q    <= '0;
      snap_coins_q <= '0;
      collected_q  <= '0;
      score_q      <= '0;
      coins_prev_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hit_q        <= hit_d;
      inc_cnt_q    <= inc_cnt_d;
      snap_px_q    <= snap_px_d;
      snap_py_q    <= snap_py_d;
      snap_cx_q    <= snap_cx_d;
      snap_cy_q    <= snap_cy_d;
      snap_coins_q <= snap_coins_d;
      collected_q  <= collected_d;
      score_q      <= score_d;
      coins_prev_q <= coins_prev_d;
    end
  end

  assign collected     = collected_q;
  assign score_bcd     = score_q;
  assign busy          = (state_q != IDLE);
  assign collect_pulse = (state_q == DONE) && (inc_cnt_q != 2'd0);

endmodule
